fp_max_issue: RTL

Operand-preparation and issue pipeline on the producer side of the `fp_max_in_type` interface.
- Accepts raw 64-bit FP operand pairs with format and rounding-mode fields over a valid/ready handshake.
- NaN-unboxes single-precision operands and computes the 10-bit class vectors and 65-bit sign/magnitude extended operands.
- Presents a complete `fp_max_in_type` bundle, two cycles later, to the min/max datapath.
- Sits between the FPU decode/register-read stage and `fp_max`, replacing per-operation ad-hoc classification.

---
 rtl/fp_max_issue.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fp_max_issue.sv
// fp_max_issue: operand preparation and issue pipeline for the fp min/max unit.
//
// Takes raw 64-bit operand pairs and format/rounding fields over a valid/ready
// handshake. Single-precision operands are NaN-unboxed. The block then works out
// the fclass vectors and the 65-bit sign/magnitude extended operands, and
// presents a complete fp_max_in_type bundle two cycles after the input.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous pipeline kill (clears both stage valids)
//   in_valid/in_ready   input handshake; in_ready depends combinationally on out_ready
//   in_data1/in_data2   raw 64-bit register operands
//   in_fmt              0 = single, otherwise double
//   in_rm               passed through (0 = min, 1 = max)
//   out_valid/out_ready output handshake for fp_max_o
//   fp_max_o            bundle: data1/2, ext1/2, fmt, rm, class1/2
//   busy                any stage holds a valid operation

package fp_max_pkg;
    typedef struct packed {
        logic [63:0] data1;
        logic [63:0] data2;
        logic [64:0] ext1;
        logic [64:0] ext2;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [9:0]  class1;
        logic [9:0]  class2;
    } fp_max_in_type;
endpackage

module fp_max_issue
    import fp_max_pkg::*;
#(
    parameter bit BOX_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data1,
    input  logic [63:0]   in_data2,
    input  logic [1:0]    in_fmt,
    input  logic [2:0]    in_rm,
    output logic          out_valid,
    input  logic          out_ready,
    output fp_max_in_type fp_max_o,
    output logic          busy
);

    // Singles that are not properly NaN-boxed become the canonical qNaN.
    function automatic logic [63:0] unbox(input logic [63:0] d, input logic is_single);
        logic [31:0] lo;
        if (!is_single) begin
            return d;
        end
        if (BOX_CHECK && (d[63:32] != 32'hFFFF_FFFF)) begin
            lo = 32'h7FC0_0000;
        end else begin
            lo = d[31:0];
        end
        return {32'b0, lo};
    endfunction

    function automatic logic [9:0] classify(input logic [63:0] d, input logic is_single);
        logic       sign;
        logic       exp_ones;
        logic       exp_zero;
        logic       mant_zero;
        logic       quiet;
        logic [9:0] cls;
        if (is_single) begin
            sign      = d[31];
            exp_ones  = &d[30:23];
            exp_zero  = ~|d[30:23];
            mant_zero = ~|d[22:0];
            quiet     = d[22];
        end else begin
            sign      = d[63];
            exp_ones  = &d[62:52];
            exp_zero  = ~|d[62:52];
            mant_zero = ~|d[51:0];
            quiet     = d[51];
        end
        cls = '0;
        if (exp_ones && !mant_zero) begin
            if (quiet) cls[9] = 1'b1;
            else       cls[8] = 1'b1;
        end else if (exp_ones) begin
            if (sign) cls[0] = 1'b1;
            else      cls[7] = 1'b1;
        end else if (exp_zero && mant_zero) begin
            if (sign) cls[3] = 1'b1;
            else      cls[4] = 1'b1;
        end else if (exp_zero) begin
            if (sign) cls[2] = 1'b1;
            else      cls[5] = 1'b1;
        end else begin
            if (sign) cls[1] = 1'b1;
            else      cls[6] = 1'b1;
        end
        return cls;
    endfunction

    // Magnitude in the low 64 bits with a zero top bit, so an unsigned compare
    // of ext[63:0] orders operands by magnitude.
    function automatic logic [64:0] extend(input logic [63:0] d, input logic is_single);
        if (is_single) begin
            return {d[31], 33'b0, d[30:0]};
        end
        return {d[63], 1'b0, d[62:0]};
    endfunction

    logic          s1_valid;
    logic [63:0]   s1_data1;
    logic [63:0]   s1_data2;
    logic [1:0]    s1_fmt;
    logic [2:0]    s1_rm;
    logic          s2_valid;
    fp_max_in_type s2_q;
    fp_max_in_type s2_next;
    logic          s1_single;
    logic          in_single;
    logic          s2_adv;
    logic          s1_adv;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv && !flush;
    assign in_single = (in_fmt == 2'd0);
    assign s1_single = (s1_fmt == 2'd0);

    always_comb begin
        s2_next        = '0;
        s2_next.data1  = s1_data1;
        s2_next.data2  = s1_data2;
        s2_next.ext1   = extend(s1_data1, s1_single);
        s2_next.ext2   = extend(s1_data2, s1_single);
        s2_next.fmt    = s1_fmt;
        s2_next.rm     = s1_rm;
        s2_next.class1 = classify(s1_data1, s1_single);
        s2_next.class2 = classify(s1_data2, s1_single);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_data1 <= '0;
            s1_data2 <= '0;
            s1_fmt   <= '0;
            s1_rm    <= '0;
            s2_q     <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s2_adv) s2_valid <= s1_valid;
                if (s1_adv) s1_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_data1 <= unbox(in_data1, in_single);
                s1_data2 <= unbox(in_data2, in_single);
                s1_fmt   <= in_fmt;
                s1_rm    <= in_rm;
            end
            // Loading only on a real transfer keeps the held bundle bit-stable.
            if (s2_adv && s1_valid && !flush) begin
                s2_q <= s2_next;
            end
        end
    end

    assign out_valid = s2_valid;
    assign fp_max_o  = s2_q;
    assign busy      = s1_valid || s2_valid;

endmodule
